// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;
    localparam logic [31:0] NOP              = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {pc, pc+4, instr} that arrived while IF/ID was stalled.
module fetch_skid_buffer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pc_plus4,
    input  logic [31:0]       in_instr,
    output logic              full,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic [31:0]       out_instr
);
    import fetch_pkg::*;

    logic              full_d, full_q;
    logic [ADDR_W-1:0] pc_d, pc_q, pc_plus4_d, pc_plus4_q;
    logic [31:0]       instr_d, instr_q;

    always_comb begin
        full_d     = full_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        if (clear || unload) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d     = 1'b1;
            pc_d       = in_pc;
            pc_plus4_d = in_pc_plus4;
            instr_d    = in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP;
        end else begin
            full_q     <= full_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
        end
    end

    assign full         = full_q;
    assign out_pc       = pc_q;
    assign out_pc_plus4 = pc_plus4_q;
    assign out_instr    = instr_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, tolerates variable imem latency, holds output under stall, flushes on redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [31:0]       if_instr
);
    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q, stale_d, stale_q, pc_plus4;
    logic              vld_d, vld_q;
    logic [ADDR_W-1:0] opc_d, opc_q, op4_d, op4_q;
    logic [31:0]       oins_d, oins_q;
    logic              new_rsp, skid_load, skid_unload, skid_clear, skid_full;
    logic [ADDR_W-1:0] skid_pc, skid_pc_plus4;
    logic [31:0]       skid_instr;
    logic              redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign new_rsp   = imem_ack && (state_q == FETCH);
    assign imem_req  = !Reset && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? stale_q : pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = new_rsp ? pc_plus4 : pc_q;
        stale_d     = stale_q;
        vld_d       = vld_q;
        opc_d       = opc_q;
        op4_d       = op4_q;
        oins_d      = oins_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            vld_d      = 1'b0;
            opc_d      = '0;
            op4_d      = '0;
            oins_d     = NOP;
            skid_clear = 1'b1;
            // An unanswered request (fresh or already stale) must be drained before refetching.
            if ((state_q == FETCH || state_q == DRAIN) && !imem_ack) begin
                state_d = DRAIN;
                if (state_q == FETCH) stale_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            if (state_q == DRAIN && imem_ack) state_d = FETCH;
            if (!stall && skid_full) begin
                vld_d       = 1'b1;
                opc_d       = skid_pc;
                op4_d       = skid_pc_plus4;
                oins_d      = skid_instr;
                skid_unload = 1'b1;
                state_d     = FETCH;
            end else if (!stall) begin
                vld_d  = new_rsp;
                opc_d  = new_rsp ? pc_q : '0;
                op4_d  = new_rsp ? pc_plus4 : '0;
                oins_d = new_rsp ? imem_rdata : NOP;
            end else if (new_rsp) begin
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    opc_d  = pc_q;
                    op4_d  = pc_plus4;
                    oins_d = imem_rdata;
                end else begin
                    skid_load = 1'b1;
                    state_d   = HOLD;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            stale_q <= '0;
            vld_q   <= 1'b0;
            opc_q   <= '0;
            op4_q   <= '0;
            oins_q  <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            vld_q   <= vld_d;
            opc_q   <= opc_d;
            op4_q   <= op4_d;
            oins_q  <= oins_d;
        end
    end

    fetch_skid_buffer #(.ADDR_W(ADDR_W)) u_skid (
        .clk          (Clk),
        .rst          (Reset),
        .load         (skid_load),
        .unload       (skid_unload),
        .clear        (skid_clear),
        .in_pc        (pc_q),
        .in_pc_plus4  (pc_plus4),
        .in_instr     (imem_rdata),
        .full         (skid_full),
        .out_pc       (skid_pc),
        .out_pc_plus4 (skid_pc_plus4),
        .out_instr    (skid_instr)
    );

    assign if_valid    = vld_q;
    assign if_pc       = opc_q;
    assign if_pc_plus4 = op4_q;
    assign if_instr    = oins_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable instruction memory model.
module tb_instr_fetch_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_pc_plus4, if_instr;
    logic        req2, v2;
    logic [31:0] addr2, pc2, p42, ins2;

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;
    int cnt = 0;

    always #5 Clk = ~Clk;

    // Memory: ack arrives in the lat-th cycle of a held request; lat=1 is zero-wait.
    always @(posedge Clk) cnt <= (!imem_req || imem_ack) ? 0 : cnt + 1;
    assign imem_ack   = imem_req && (cnt == lat - 1);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    instr_fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(v2),
        .if_pc(pc2), .if_pc_plus4(p42), .if_instr(ins2)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1;
        do_reset();
        Reset = 1'b1;
        #1;
        vectors++;
        if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_req} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b pc=%h pc4=%h instr=%h req=%0b, want all 0",
                     if_valid, if_pc, if_pc_plus4, if_instr, imem_req);
        end
        Reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] wpc[3];
        logic [31:0] wp4[3];
        wpc[0] = 32'hFFFF_FFF8; wpc[1] = 32'hFFFF_FFFC; wpc[2] = 32'h0000_0000;
        wp4[0] = 32'hFFFF_FFFC; wp4[1] = 32'h0000_0000; wp4[2] = 32'h0000_0004;
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            step();
            e = 32'(i * 4);
            vectors++;
            if (!(if_valid === 1'b1 && if_pc === e && if_pc_plus4 === e + 4 &&
                  if_instr === (e ^ 32'hA5A5_0000))) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%0b pc=%h pc4=%h instr=%h, want 1 %h %h %h",
                         i, if_valid, if_pc, if_pc_plus4, if_instr, e, e + 4, e ^ 32'hA5A5_0000);
            end
            if (i < 3) begin
                vectors++;
                if (!(v2 === 1'b1 && pc2 === wpc[i] && p42 === wp4[i])) begin
                    miscompares++;
                    $display("FAIL wrap[%0d]: valid=%0b pc=%h pc4=%h, want 1 %h %h",
                             i, v2, pc2, p42, wpc[i], wp4[i]);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] e;
        lat = 3;
        e = 32'd16;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (i % 3 == 2) begin
                if (!(if_valid === 1'b1 && if_pc === e && if_instr === (e ^ 32'hA5A5_0000))) begin
                    miscompares++;
                    $display("FAIL latency[%0d]: valid=%0b pc=%h instr=%h, want 1 %h", i,
                             if_valid, if_pc, if_instr, e);
                end
                e = e + 4;
            end else if (!(if_valid === 1'b0 && imem_req === 1'b1 && imem_addr === e)) begin
                miscompares++;
                $display("FAIL latency_wait[%0d]: valid=%0b req=%0b addr=%h, want 0 1 %h", i,
                         if_valid, imem_req, imem_addr, e);
            end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (!(if_valid === 1'b1 && if_pc === 32'd8 && imem_req === 1'b0)) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%0b pc=%h req=%0b, want 1 00000008 0", i,
                         if_valid, if_pc, imem_req);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            step();
            e = 32'(12 + 4 * i);
            vectors++;
            if (!(if_valid === 1'b1 && if_pc === e && if_instr === (e ^ 32'hA5A5_0000))) begin
                miscompares++;
                $display("FAIL stall_release[%0d]: valid=%0b pc=%h instr=%h, want 1 %h", i,
                         if_valid, if_pc, if_instr, e);
            end
        end
    endtask

    task automatic test_redirect();
        lat = 2;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (!(if_valid === 1'b0 && imem_req === 1'b1 && imem_addr === 32'h0)) begin
            miscompares++;
            $display("FAIL redirect_drain: valid=%0b req=%0b addr=%h, want 0 1 00000000",
                     if_valid, imem_req, imem_addr);
        end
        step();
        vectors++;
        if (!(if_valid === 1'b0 && imem_addr === 32'h100)) begin
            miscompares++;
            $display("FAIL redirect_stale_drop: valid=%0b addr=%h, want 0 00000100", if_valid, imem_addr);
        end
        step();
        step();
        vectors++;
        if (!(if_valid === 1'b1 && if_pc === 32'h100 && if_pc_plus4 === 32'h104 &&
              if_instr === 32'hA5A5_0100)) begin
            miscompares++;
            $display("FAIL redirect_target: valid=%0b pc=%h pc4=%h instr=%h, want 1 00000100 00000104 a5a50100",
                     if_valid, if_pc, if_pc_plus4, if_instr);
        end
    endtask

    task automatic test_redirect_stall();
        lat = 1;
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (!(if_valid === 1'b0 && if_instr === 32'h0 && imem_req === 1'b1 && imem_addr === 32'h200)) begin
            miscompares++;
            $display("FAIL flush_over_stall: valid=%0b instr=%h req=%0b addr=%h, want 0 0 1 00000200",
                     if_valid, if_instr, imem_req, imem_addr);
        end
        stall = 1'b0;
        step();
        vectors++;
        if (!(if_valid === 1'b1 && if_pc === 32'h200)) begin
            miscompares++;
            $display("FAIL flush_skid_cleared: valid=%0b pc=%h, want 1 00000200", if_valid, if_pc);
        end
    endtask

    task automatic test_async_reset();
        lat = 1;
        do_reset();
        step(); step();
        vectors++;
        if (!(if_valid === 1'b1 && if_pc === 32'd4)) begin
            miscompares++;
            $display("FAIL pre_reset_run: valid=%0b pc=%h, want 1 00000004", if_valid, if_pc);
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_req, v2, pc2, req2} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b pc=%h pc4=%h instr=%h req=%0b wrap_valid=%0b wrap_pc=%h, want all 0",
                     if_valid, if_pc, if_pc_plus4, if_instr, imem_req, v2, pc2);
        end
        step();
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues requests to instruction memory and absorbs variable memory latency.
- Presents {PC, PC+4, instruction, valid} to IF/ID, holding them while the hazard unit stalls.
- Applies branch/jump redirects with a flush that discards wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width; instruction width is fixed at 32.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit holds IF/ID; IF/ID WRITE = ~stall.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 00).
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  response valid this cycle; may be high in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction data, valid when imem_ack=1.
- if_valid  out  1  presented instruction is real; 0 means bubble.
- if_pc  out  ADDR_W  PC of the presented instruction (feeds IF/ID PCIn).
- if_pc_plus4  out  ADDR_W  if_pc+4 (feeds IF/ID PCADDEDIN).
- if_instr  out  32  instruction; 32'h0 (NOP) when if_valid=0.

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, state=FETCH, skid empty.
  - if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0.
  - imem_req forced 0 while Reset is high.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: skid full, imem_req=0.
  - DRAIN: imem_req=1, imem_addr=stale_addr; response is discarded.
- Accepted response: new = imem_ack & (state==FETCH). On new: pc <= pc+4, modulo 2^ADDR_W, wrap 32'hFFFF_FFFC -> 0.
- Output/skid update per edge, in priority order:
  1. redirect_valid=1:
     - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; output regs cleared to bubble; skid cleared.
     - If state==FETCH and imem_ack=0 (request outstanding): stale_addr <= imem_addr, state -> DRAIN. Otherwise state -> FETCH.
     - Any response arriving this cycle is discarded.
     - Redirect overrides stall.
  2. stall=0 and skid full: output <= skid, skid emptied, state HOLD -> FETCH.
  3. stall=0 and skid empty: output <= new data {pc, pc+4, rdata, 1} if new, else bubble.
  4. stall=1: output held.
     - If new and output invalid: output <= new.
     - If new and output valid: skid <= new, state -> HOLD.
- DRAIN:
  - On imem_ack: data dropped, state -> FETCH.
  - A redirect while in DRAIN only updates pc; stays in DRAIN until the ack.
- Ordering and capacity:
  - At most one outstanding request; no request is issued while in HOLD.
  - The skid never overflows.
  - Program order is preserved.
- Throughput and latency:
  - With imem_ack tied 1: one instruction per cycle.
  - First if_valid=1 appears at the first rising edge after Reset deasserts.
- Reset mid-operation: outstanding response abandoned; memory must tolerate req dropping.

Decomposition:
- Shared package `fetch_pkg`:
  - State enum {FETCH, HOLD, DRAIN}.
  - NOP constant 32'h0.
  - Default RESET_PC.
- One natural sub-module: `fetch_skid_buffer`, a one-entry holding register for {pc, pc+4, instr} with load/unload/clear.
- The FSM and PC logic stay in the top module.

Test Plan:
- Reset then release, imem_ack=1, rdata=pc^32'hA5A5_0000, stall=0 -> if_pc 0,4,8,12 on consecutive edges, if_pc_plus4=if_pc+4, if_instr matches, if_valid=1 from first edge.
- Memory acks 3 cycles after req -> if_valid pattern 0,0,1 repeating; imem_addr stable until ack; pc advances by 4 per ack only.
- stall=1 for 4 cycles with ack=1 -> if_pc frozen at 8; one extra fetch (pc 12) captured in skid; imem_req=0 in HOLD; on stall=0, if_pc sequence 12 then 16 with no gap or duplicate.
- redirect_valid with redirect_pc=32'h0000_0103 while a 2-cycle request is outstanding -> bubble next edge; stale ack discarded (DRAIN); next valid if_pc=32'h100.
- redirect and stall both high in the same cycle -> flush wins; pc=target; skid cleared; if_valid=0.
- RESET_PC=32'hFFFF_FFF8, ack=1 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap); Reset asserted mid-stream -> all outputs 0 immediately, asynchronously.
